// File: rtl/sw_debounce.sv
// Slide-switch conditioner: two-flop synchroniser, per-bit stable-time filter, change strobe.
// Define SW_DEBOUNCE_EDGE_EN to add registered per-bit rise/fall pulse outputs.
module sw_debounce #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sw_raw,
  output logic [WIDTH-1:0] o_sw_clean,
`ifdef SW_DEBOUNCE_EDGE_EN
  output logic [WIDTH-1:0] o_sw_rise,
  output logic [WIDTH-1:0] o_sw_fall,
`endif
  output logic             o_sw_changed
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES-1");
  end

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_clean;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [WIDTH-1:0] w_mismatch;
  logic [WIDTH-1:0] w_update;

  // A bit commits once its mismatch has persisted for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    w_mismatch = r_sync2 ^ r_clean;
    w_update   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_update[i] = w_mismatch[i] && (r_cnt[i] == LastCnt);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_clean   <= '0;
      r_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= i_sw_raw;
      r_sync2   <= r_sync1;
      r_changed <= |w_update;
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_mismatch[i]) begin
          r_cnt[i] <= '0;
        end else if (w_update[i]) begin
          r_clean[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign o_sw_clean   = r_clean;
  assign o_sw_changed = r_changed;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // Direction of an update is the value being committed from sync2.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_update & r_sync2;
      r_fall <= w_update & ~r_sync2;
    end
  end

  assign o_sw_rise = r_rise;
  assign o_sw_fall = r_fall;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: window-based reference model checked every cycle plus directed scenarios.
module tb_sw_debounce;
  localparam int W  = 3;
  localparam int D  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw;
  logic [W-1:0] clean;
  logic         changed;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [W-1:0] rise;
  logic [W-1:0] fall;
`endif

  sw_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_sw_raw    (raw),
    .o_sw_clean  (clean),
`ifdef SW_DEBOUNCE_EDGE_EN
    .o_sw_rise   (rise),
    .o_sw_fall   (fall),
`endif
    .o_sw_changed(changed)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int pulses = 0;
  int pulse_edges[$];
  int rise_seen = 0;
  int fall_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp, edge_no);
    end
  endtask

  // Reference model: a bit flips when the last D synchronised samples since reset all disagree
  // with its current clean value.
  logic [W-1:0] m_s1, m_s2, m_clean, m_rise, m_fall;
  logic         m_changed;
  logic [W-1:0] win[$];

  task automatic model_step();
    logic [W-1:0] upd;
    logic         all_diff;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_changed = 1'b0;
      m_rise = '0; m_fall = '0;
      win.delete();
    end else begin
      win.push_back(m_s2);
      if (win.size() > D) void'(win.pop_front());
      upd = '0;
      for (int i = 0; i < W; i++) begin
        all_diff = (win.size() == D);
        for (int j = 0; j < win.size(); j++) begin
          if (win[j][i] == m_clean[i]) all_diff = 1'b0;
        end
        upd[i] = all_diff;
      end
      m_clean   = m_clean ^ upd;
      m_changed = |upd;
      m_rise    = upd & m_clean;
      m_fall    = upd & ~m_clean;
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      edge_no++;
      check("clean", clean, m_clean);
      check("changed", changed, m_changed);
`ifdef SW_DEBOUNCE_EDGE_EN
      check("rise", rise, m_rise);
      check("fall", fall, m_fall);
      if (rise != 0) begin
        rise_seen++;
        check("rise_coincident", changed, 1'b1);
      end
      if (fall != 0) begin
        fall_seen++;
        check("fall_coincident", changed, 1'b1);
      end
`endif
      if (changed === 1'b1) begin
        pulses++;
        pulse_edges.push_back(edge_no);
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_pulse(input int n);
    rst = 1'b1;
    ticks(n);
    rst = 1'b0;
  endtask

  int start, p0, set_edge;

  initial begin
    rst = 1'b1;
    raw = 3'b101;
    // 1: reset held ~125 ns with raw=101
    ticks(6);
    check("t1_clean_in_reset", clean, 3'b000);
    check("t1_no_pulse_in_reset", pulses, 0);
    rst = 1'b0;
    start = edge_no;
    ticks(4);
    check("t1_clean_early", clean, 3'b000);
    ticks(8);
    check("t1_clean", clean, 3'b101);
    check("t1_pulses", pulses, 1);
    // first post-release edge samples raw; commit D+1 edges after that
    if (pulse_edges.size() > 0) check("t1_latency", pulse_edges[pulse_edges.size()-1] - start, D + 2);

    // 2: short glitch on bit0 is filtered
    raw = 3'b000;
    reset_pulse(1);
    ticks(3);
    p0 = pulses;
    raw[0] = 1'b1;
    ticks(3);
    raw[0] = 1'b0;
    ticks(10);
    check("t2_clean", clean, 3'b000);
    check("t2_no_pulse", pulses - p0, 0);

    // 3: bit1 toggles every edge, then held high
    p0 = pulses;
    for (int i = 0; i < 6; i++) begin
      raw[1] = (i % 2 == 0);
      ticks(1);
    end
    raw[1] = 1'b1;
    set_edge = edge_no + 1;
    ticks(12);
    check("t3_clean", clean, 3'b010);
    check("t3_pulses", pulses - p0, 1);
    check("t3_latency", pulse_edges[pulse_edges.size()-1] - set_edge, D + 1);

    // 4: bit0 and bit2 rise two edges apart
    p0 = pulses;
    raw[0] = 1'b1;
    ticks(2);
    raw[2] = 1'b1;
    ticks(12);
    check("t4_clean", clean, 3'b111);
    check("t4_pulses", pulses - p0, 2);
    check("t4_spacing", pulse_edges[pulse_edges.size()-1] - pulse_edges[pulse_edges.size()-2], 2);

    // 5: reset mid-count discards progress
    raw = 3'b000;
    reset_pulse(1);
    ticks(8);
    check("t5_clean_zero", clean, 3'b000);
    raw = 3'b111;
    ticks(3);
    rst = 1'b1;
    ticks(1);
    check("t5_clean_after_reset", clean, 3'b000);
    rst = 1'b0;
    start = edge_no;
    p0 = pulses;
    ticks(5);
    check("t5_clean_early", clean, 3'b000);
    ticks(6);
    check("t5_clean", clean, 3'b111);
    check("t5_pulses", pulses - p0, 1);
    check("t5_latency", pulse_edges[pulse_edges.size()-1] - start, D + 2);

`ifdef SW_DEBOUNCE_EDGE_EN
    // 6: bit2 0->1->0, 8 edges per level
    raw = 3'b000;
    reset_pulse(1);
    ticks(8);
    rise_seen = 0;
    fall_seen = 0;
    raw = 3'b100;
    ticks(8);
    check("t6_clean_high", clean, 3'b100);
    raw = 3'b000;
    ticks(8);
    check("t6_clean_low", clean, 3'b000);
    check("t6_rise_count", rise_seen, 1);
    check("t6_fall_count", fall_seen, 1);
`endif

    ticks(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
